// File: rtl/csa_pkg.sv
// ============================================================================
// Module   : csa_pkg
// Brief    : Shared types and sizing helpers for the byte-serial carry-skip
//            adder front end.
// Revision : 1.0
// ============================================================================
`default_nettype none

package csa_pkg;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } csa_state_e;

    // Bit positions inside the optional trailing status byte
    localparam int STATUS_CARRY_BIT = 0;
    localparam int STATUS_OVF_BIT   = 1;

    function automatic int bytes_of(input int width);
        return width / 8;
    endfunction

    function automatic int slices_of(input int width, input int block);
        return width / block;
    endfunction

    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/csa_skip_block.sv
// ============================================================================
// Module   : csa_skip_block
// Brief    : Combinational BLOCK-bit ripple adder slice with carry-skip mux.
// Revision : 1.0
// ============================================================================
`default_nettype none

module csa_skip_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout
);

    logic w_prop;
    logic w_ripple;

    always_comb begin
        logic v_c;
        v_c = cin;
        sum = '0;
        for (int i = 0; i < BLOCK; i++) begin
            sum[i] = a[i] ^ b[i] ^ v_c;
            v_c    = (a[i] & b[i]) | (v_c & (a[i] ^ b[i]));
        end
        w_ripple = v_c;
    end

    // When every bit propagates the ripple carry equals cin, so the mux is exact
    assign w_prop = &(a ^ b);
    assign cout   = w_prop ? cin : w_ripple;

endmodule

`default_nettype wire

// File: rtl/csa_byte_sequencer.sv
// ============================================================================
// Module   : csa_byte_sequencer
// Brief    : Byte-serial operand loader, slice-serial carry-skip adder and
//            byte-serial result drain. CSA_STATUS_BYTE_EN appends a status
//            byte {6'b0, overflow, carry_out} after the sum bytes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module csa_byte_sequencer
    import csa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       carry_out,
    output logic       overflow
);

    localparam int BYTES  = bytes_of(WIDTH);
    localparam int SLICES = slices_of(WIDTH, BLOCK);
`ifdef CSA_STATUS_BYTE_EN
    localparam int OUT_BYTES = BYTES + 1;
`else
    localparam int OUT_BYTES = BYTES;
`endif
    localparam int BCW = cnt_w(OUT_BYTES);
    localparam int SCW = cnt_w(SLICES);

    localparam logic [BCW-1:0] LAST_IN    = BCW'(BYTES - 1);
    localparam logic [BCW-1:0] LAST_OUT   = BCW'(OUT_BYTES - 1);
    localparam logic [BCW-1:0] STATUS_IDX = BCW'(BYTES);
    localparam logic [SCW-1:0] LAST_SLICE = SCW'(SLICES - 1);

    csa_state_e       state_q,     state_d;
    logic [BCW-1:0]   byte_cnt_q,  byte_cnt_d;
    logic [SCW-1:0]   slice_cnt_q, slice_cnt_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic [WIDTH-1:0] s_q,         s_d;
    logic             carry_q,     carry_d;
    logic [7:0]       out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q,  overflow_d;

    logic [BLOCK-1:0]       w_sum;
    logic                   w_cout;
    logic                   w_in_fire;
    logic                   w_out_fire;
    logic [WIDTH+7:0]       w_a_ld;
    logic [WIDTH+7:0]       w_b_ld;
    logic [WIDTH+BLOCK-1:0] w_s_cat;
    logic [WIDTH-1:0]       w_s_new;
    logic [7:0]             w_status;

    // Operands shift right as slices are consumed, so the active slice is always the low BLOCK bits
    csa_skip_block #(.BLOCK(BLOCK)) u_skip (
        .a    (a_q[BLOCK-1:0]),
        .b    (b_q[BLOCK-1:0]),
        .cin  (carry_q),
        .sum  (w_sum),
        .cout (w_cout)
    );

    assign in_ready   = !rst && ((state_q == LOAD_A) || (state_q == LOAD_B));
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid_q && out_ready;

    assign w_a_ld  = {in_data, a_q};
    assign w_b_ld  = {in_data, b_q};
    assign w_s_cat = {w_sum, s_q};
    assign w_s_new = w_s_cat[WIDTH+BLOCK-1:BLOCK];

    always_comb begin
        w_status                   = 8'h00;
        w_status[STATUS_CARRY_BIT] = carry_out_q;
        w_status[STATUS_OVF_BIT]   = overflow_q;
    end

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        slice_cnt_d = slice_cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        s_d         = s_q;
        carry_d     = carry_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        case (state_q)
            LOAD_A: begin
                if (w_in_fire) begin
                    a_d = w_a_ld[WIDTH+7:8];
                    if (byte_cnt_q == LAST_IN) begin
                        byte_cnt_d = '0;
                        state_d    = LOAD_B;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (w_in_fire) begin
                    b_d = w_b_ld[WIDTH+7:8];
                    if (byte_cnt_q == LAST_IN) begin
                        byte_cnt_d  = '0;
                        slice_cnt_d = '0;
                        carry_d     = 1'b0;
                        state_d     = COMPUTE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                a_d     = a_q >> BLOCK;
                b_d     = b_q >> BLOCK;
                s_d     = w_s_new;
                carry_d = w_cout;
                if (slice_cnt_q == LAST_SLICE) begin
                    // Last slice holds the operand MSBs; present byte 0 on this same edge
                    carry_out_d = w_cout;
                    overflow_d  = (a_q[BLOCK-1] == b_q[BLOCK-1]) &&
                                  (w_sum[BLOCK-1] != a_q[BLOCK-1]);
                    out_data_d  = w_s_new[7:0];
                    s_d         = w_s_new >> 8;
                    out_valid_d = 1'b1;
                    byte_cnt_d  = '0;
                    slice_cnt_d = '0;
                    state_d     = DRAIN;
                end else begin
                    slice_cnt_d = slice_cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (w_out_fire) begin
                    if (byte_cnt_q == LAST_OUT) begin
                        out_valid_d = 1'b0;
                        byte_cnt_d  = '0;
                        state_d     = LOAD_A;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        out_data_d = ((byte_cnt_q + 1'b1) == STATUS_IDX) ? w_status : s_q[7:0];
                        s_d        = s_q >> 8;
                    end
                end
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD_A;
            byte_cnt_q  <= '0;
            slice_cnt_q <= '0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            carry_q     <= 1'b0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            slice_cnt_q <= slice_cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            carry_q     <= carry_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == COMPUTE) || (state_q == DRAIN);
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_csa_byte_sequencer.sv
// ============================================================================
// Module   : tb_csa_byte_sequencer
// Brief    : Directed self-checking bench for csa_byte_sequencer (honours
//            CSA_STATUS_BYTE_EN when defined).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_csa_byte_sequencer;

    localparam int WIDTH  = 16;
    localparam int BLOCK  = 4;
    localparam int BYTES  = 2;
    localparam int SLICES = 4;
`ifdef CSA_STATUS_BYTE_EN
    localparam int OUT_BYTES = BYTES + 1;
`else
    localparam int OUT_BYTES = BYTES;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       carry_out;
    logic       overflow;

    logic [3:0] sb_a;
    logic [3:0] sb_b;
    logic       sb_cin;
    logic [3:0] sb_sum;
    logic       sb_cout;

    int n_total;
    int n_bad;

    csa_byte_sequencer #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    csa_skip_block #(.BLOCK(BLOCK)) u_sb (
        .a    (sb_a),
        .b    (sb_b),
        .cin  (sb_cin),
        .sum  (sb_sum),
        .cout (sb_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        logic r;
        int   k;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        k = 0;
        do begin
            r = in_ready;
            @(posedge clk); #1;
            k++;
        end while (!r && k < 50);
        check("send_ready", {31'd0, r}, 32'd1);
    endtask

    task automatic send_ops(input logic [15:0] a, input logic [15:0] b, input bit gaps);
        send_byte(a[7:0],  gaps ? int'($urandom_range(0, 2)) : 0);
        send_byte(a[15:8], gaps ? int'($urandom_range(0, 2)) : 0);
        send_byte(b[7:0],  gaps ? int'($urandom_range(0, 2)) : 0);
        send_byte(b[15:8], gaps ? int'($urandom_range(0, 2)) : 0);
    endtask

    task automatic run_vec(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_s, input logic exp_c, input logic exp_v,
                           input bit gaps, input bit hold_valid, input bit bp);
        logic [7:0] exp_b [3];
        int k;
        exp_b[0] = exp_s[7:0];
        exp_b[1] = exp_s[15:8];
        exp_b[2] = {6'b0, exp_v, exp_c};

        send_ops(a, b, gaps);
        in_valid = hold_valid;
        in_data  = 8'hEE;

        k = 0;
        while (!out_valid && k < 20) begin
            if (k == 0) begin
                check("busy_compute", {31'd0, busy}, 32'd1);
                check("in_ready_compute", {31'd0, in_ready}, 32'd0);
            end
            @(posedge clk); #1;
            k++;
        end
        check("latency", k, SLICES);
        check("carry_out", {31'd0, carry_out}, {31'd0, exp_c});
        check("overflow", {31'd0, overflow}, {31'd0, exp_v});

        for (int i = 0; i < OUT_BYTES; i++) begin
            if (bp && i == 1) begin
                out_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1;
                    check("bp_data", {24'd0, out_data}, {24'd0, exp_b[i]});
                    check("bp_valid", {31'd0, out_valid}, 32'd1);
                end
                out_ready = 1'b1;
            end
            check("in_ready_drain", {31'd0, in_ready}, 32'd0);
            if (i == OUT_BYTES - 1) in_valid = 1'b0;
            k = 0;
            while (!out_valid && k < 20) begin
                @(posedge clk); #1;
                k++;
            end
            check($sformatf("byte%0d", i), {24'd0, out_data}, {24'd0, exp_b[i]});
            @(posedge clk); #1;
        end

        check("post_valid", {31'd0, out_valid}, 32'd0);
        check("post_busy", {31'd0, busy}, 32'd0);
        check("post_in_ready", {31'd0, in_ready}, 32'd1);
        check("carry_hold", {31'd0, carry_out}, {31'd0, exp_c});
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        sb_a      = '0;
        sb_b      = '0;
        sb_cin    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_carry", {31'd0, carry_out}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);

        // Skip path and ripple path must both produce the true sum
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            logic [4:0] ref_sum;
            v      = i[8:0];
            sb_a   = v[3:0];
            sb_b   = v[7:4];
            sb_cin = v[8];
            ref_sum = {1'b0, v[3:0]} + {1'b0, v[7:4]} + {4'd0, v[8]};
            #1;
            check("skip_block", {27'd0, sb_cout, sb_sum}, {27'd0, ref_sum});
        end

        @(posedge clk); #1;
        run_vec(16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_vec(16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        run_vec(16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_vec(16'hA5A5, 16'h5A5A, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_vec(16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // Reset pulse two cycles into COMPUTE
        send_ops(16'h1234, 16'h4321, 1'b0);
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mr_in_ready_rst", {31'd0, in_ready}, 32'd0);
        check("mr_out_valid", {31'd0, out_valid}, 32'd0);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_carry", {31'd0, carry_out}, 32'd0);
        check("mr_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        #1;
        check("mr_in_ready", {31'd0, in_ready}, 32'd1);
        run_vec(16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
